vpu_line_rasterizer: RTL and testbench
======================================

// Module: vpu_line_rasterizer
// PURPOSE
//  Bresenham line rasterizer between the clipper and the framebuffer write port.
//  Accepts one clipped line (two screen-space endpoints plus colour) per handshake.
//  Emits every pixel of that line, endpoints inclusive, as a valid/ready pixel-write stream.
//  Handles all eight octants, degenerate lines and a synchronous abort.
// PARAMETERS
//  X_W      10  x coordinate width (unsigned, 640-wide screen)
//  Y_W       9  y coordinate width (unsigned, 480-high screen)
//  COLOR_W   3  colour index width, passed through unchanged
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous reset, active-high
//  line_valid  in   1        line endpoints/colour valid
//  line_ready  out  1        rasterizer can accept a line
//  x0, x1      in   X_W      start/end x (unsigned)
//  y0, y1      in   Y_W      start/end y (unsigned)
//  color       in   COLOR_W  line colour
//  abort       in   1        synchronous abort of current line
//  px_valid    out  1        pixel write valid
//  px_ready    in   1        framebuffer accepts pixel
//  px_x        out  X_W      pixel x
//  px_y        out  Y_W      pixel y
//  px_color    out  COLOR_W  pixel colour
//  line_done   out  1        one-cycle pulse when the last pixel of a line is accepted
// BEHAVIOUR
//  Reset: state=IDLE, line_ready=1, px_valid=0, px_x=0, px_y=0, px_color=0, line_done=0,
//   all internal registers 0.
//  States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
//  IDLE: line_ready=1. On line_valid&&line_ready, latch x0,y0,x1,y1,color; go to SETUP.
//   line_ready is 0 in every other state.
//  SETUP (1 cycle) computes:
//   dx=|x1-x0|, dy=-|y1-y0|, sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1, err=dx+dy.
//   It loads x=x0, y=y0, then goes to DRAW.
//   Registers are signed, W=max(X_W,Y_W)+2 bits. e2=2*err is W+1 bits. No overflow is possible.
//  DRAW: px_valid=1 with px_x=x, px_y=y, px_color=latched colour.
//   First px_valid is asserted 2 cycles after line acceptance.
//   While px_valid && !px_ready, px_x, px_y and px_color are held stable (no step).
//   On px_valid&&px_ready:
//    - if x==x1 && y==y1: go to DONE.
//    - else compute e2=2*err from the old err, then apply:
//      if e2>=dy: err+=dy, x+=sx
//      if e2<=dx: err+=dx, y+=sy
//      Both conditions may apply in the same cycle; both additions are summed into err.
//   Throughput: 1 pixel/cycle while px_ready=1.
//  DONE (1 cycle): px_valid=0, line_done=1, then IDLE.
//   Next line accepted no earlier than the cycle after DONE.
//  Pixel count is exactly max(|x1-x0|,|y1-y0|)+1. x and y never leave the endpoint bounding box.
//  Degenerate (x0==x1, y0==y1): exactly one pixel, then DONE.
//  abort=1 in SETUP/DRAW/DONE: next state is IDLE, px_valid=0 next cycle, no line_done.
//   A pixel handshaking in the abort cycle counts as written.
//   abort in IDLE is ignored; abort and line_valid together in IDLE accepts the line.
//  Reset mid-line: immediate return to reset values; the partial line is discarded.
//  px_ready is ignored when px_valid=0. Inputs x0..color are only sampled at acceptance.
// TESTING
//  1. Line (0,0)-(3,0), px_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles;
//     line_done 1 cycle after the last one.
//  2. Steep (0,0)-(2,5) -> 6 pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); y steps every pixel.
//  3. Reversed (5,5)-(0,3) -> 6 pixels, x decreasing 5..0, first (5,5), last (0,3).
//  4. Point (7,9)-(7,9) -> exactly one pixel (7,9), then line_done; line_ready back to 1.
//  5. Full diagonal (639,479)-(0,0) with px_ready toggling randomly -> 640 pixels;
//     outputs stable during stalls; sequence identical to the px_ready=1 run.
//  6. abort on the 3rd pixel of (0,0)-(10,0) -> px_valid=0 next cycle, no line_done,
//     line_ready=1; next line (1,1)-(2,1) draws 2 pixels.
//  7. Assert rst during DRAW -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/vpu_line_rasterizer.sv
// vpu_line_rasterizer
//   Bresenham line rasterizer between the clipper and the framebuffer write
//   port. It takes one clipped line per handshake and emits every pixel of
//   the line, both endpoints included, as a valid/ready pixel-write stream.
//   All eight octants, single-point lines and a synchronous abort are handled.
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   line_valid/line_ready line handshake; x0,y0,x1,y1,color sampled on accept
//   abort                 drops the current line (ignored while idle)
//   px_valid/px_ready     pixel-write handshake carrying px_x, px_y, px_color
//   line_done             one-cycle pulse after the last pixel is accepted
//
// state   | meaning
// S_IDLE  | waiting for a line, line_ready high
// S_SETUP | derive deltas, step directions and initial error term
// S_DRAW  | present current pixel, step on each accepted pixel
// S_DONE  | line finished, pulse line_done
module vpu_line_rasterizer #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_valid,
  output logic               line_ready,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic [COLOR_W-1:0] color,
  input  logic               abort,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [X_W-1:0]     px_x,
  output logic [Y_W-1:0]     px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               line_done
);

  localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic signed [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t state_q, state_d;

  logic [X_W-1:0]     x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]     y0_q, y0_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d, x_q, x_d, y_q, y_d;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic signed [W-1:0] x0_s, x1_s, y0_s, y1_s, err_n;
  logic signed [W:0]   e2, dx_ext, dy_ext;

  assign x0_s = {{(W-X_W){1'b0}}, x0_q};
  assign x1_s = {{(W-X_W){1'b0}}, x1_q};
  assign y0_s = {{(W-Y_W){1'b0}}, y0_q};
  assign y1_s = {{(W-Y_W){1'b0}}, y1_q};

  // Error term doubled one bit wider; deltas sign-extended to match.
  assign e2     = {err_q, 1'b0};
  assign dx_ext = {dx_q[W-1], dx_q};
  assign dy_ext = {dy_q[W-1], dy_q};

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    color_d  = color_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    x_d      = x_q;
    y_d      = y_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_n    = err_q;

    case (state_q)
      S_IDLE: begin
        if (line_valid) begin
          x0_d    = x0;
          x1_d    = x1;
          y0_d    = y0;
          y1_d    = y1;
          color_d = color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d     = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
        dy_d     = (y1_s >= y0_s) ? (y0_s - y1_s) : (y1_s - y0_s);
        sx_neg_d = !(x0_s < x1_s);
        sy_neg_d = !(y0_s < y1_s);
        err_d    = dx_d + dy_d;
        x_d      = x0_s;
        y_d      = y0_s;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (px_ready) begin
          if (x_q == x1_s && y_q == y1_s) begin
            state_d = S_DONE;
          end else begin
            // Both steps may fire together; their error updates accumulate.
            if (e2 >= dy_ext) begin
              err_n = err_n + dy_q;
              x_d   = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
            end
            if (e2 <= dx_ext) begin
              err_n = err_n + dx_q;
              y_d   = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
            end
            err_d = err_n;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      color_q  <= color_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign line_ready = (state_q == S_IDLE);
  assign px_valid   = (state_q == S_DRAW);
  assign px_x       = x_q[X_W-1:0];
  assign px_y       = y_q[Y_W-1:0];
  assign px_color   = color_q;
  // An abort arriving in the done cycle suppresses the completion pulse.
  assign line_done  = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_vpu_line_rasterizer.sv
// Directed bench for vpu_line_rasterizer: hand-computed pixel lists for short
// lines, a full-screen diagonal under random back-pressure, abort and
// mid-line reset.
module tb_vpu_line_rasterizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_valid, line_ready;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic [2:0] color;
  logic       abort;
  logic       px_valid, px_ready;
  logic [9:0] px_x;
  logic [8:0] px_y;
  logic [2:0] px_color;
  logic       line_done;

  vpu_line_rasterizer #(.X_W(10), .Y_W(9), .COLOR_W(3)) dut (
    .clk(clk), .rst(rst),
    .line_valid(line_valid), .line_ready(line_ready),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .abort(abort),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [18:0] got[$];
  logic [18:0] ref_q[$];
  int          exp_x[$];
  int          exp_y[$];
  int          done_cyc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one line and collects every accepted pixel into got.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic [2:0] c, input bit rnd, input bit ab_accept);
    int          cyc;
    int          last_acc;
    bit          fin;
    logic        pv_prev, pr_prev;
    logic [18:0] pix_prev;
    got.delete();
    done_cyc = -1;
    chk("ready_idle", line_ready, 1);
    x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1); color = c;
    line_valid = 1'b1;
    abort      = ab_accept;
    step();
    line_valid = 1'b0;
    abort      = 1'b0;
    chk("setup_no_valid", px_valid, 0);
    chk("setup_not_ready", line_ready, 0);
    step();
    chk("first_valid", px_valid, 1);
    pv_prev = 1'b0; pr_prev = 1'b0; pix_prev = '0;
    cyc = 0; fin = 1'b0; last_acc = -10;
    while (!fin && cyc < 5000) begin
      if (pv_prev && !pr_prev)
        chk("stall_hold", {px_valid, px_x, px_y, px_color}, {1'b1, pix_prev, c});
      if (line_done) begin
        fin      = 1'b1;
        done_cyc = cyc;
        chk("done_latency", cyc - last_acc, 1);
      end else begin
        px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (px_valid && px_ready) begin
          got.push_back({px_x, px_y});
          last_acc = cyc;
          if (px_color !== c) chk("px_color", px_color, c);
        end
        pv_prev  = px_valid;
        pr_prev  = px_ready;
        pix_prev = {px_x, px_y};
        step();
        cyc++;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    px_ready = 1'b0;
    step();
    chk("done_one_cycle", line_done, 0);
    chk("ready_after_done", line_ready, 1);
  endtask

  task automatic check_pixels(input string tag);
    int n;
    n = (got.size() < exp_x.size()) ? got.size() : exp_x.size();
    chk({tag, "_count"}, got.size(), exp_x.size());
    for (int i = 0; i < n; i++)
      chk({tag, "_pix"}, got[i], {10'(exp_x[i]), 9'(exp_y[i])});
    chk({tag, "_done_cycle"}, done_cyc, exp_x.size());
  endtask

  initial begin
    int diffs;
    int seen_done;
    rst = 1'b1; line_valid = 1'b0; abort = 1'b0; px_ready = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line_ready", line_ready, 1);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_px_xy", {px_x, px_y}, 0);
    chk("rst_px_color", px_color, 0);
    chk("rst_line_done", line_done, 0);
    rst = 1'b0;
    step();

    // Horizontal line.
    exp_x = '{0, 1, 2, 3}; exp_y = '{0, 0, 0, 0};
    run_line(0, 0, 3, 0, 3'd5, 1'b0, 1'b0);
    check_pixels("horiz");

    // Steep line, y steps on every pixel.
    exp_x = '{0, 0, 1, 1, 2, 2}; exp_y = '{0, 1, 2, 3, 4, 5};
    run_line(0, 0, 2, 5, 3'd3, 1'b0, 1'b0);
    check_pixels("steep");

    // Reversed direction in both axes.
    exp_x = '{5, 4, 3, 2, 1, 0}; exp_y = '{5, 5, 4, 4, 3, 3};
    run_line(5, 5, 0, 3, 3'd6, 1'b0, 1'b0);
    check_pixels("reverse");

    // Single point, accepted while abort is also high in IDLE.
    exp_x = '{7}; exp_y = '{9};
    run_line(7, 9, 7, 9, 3'd1, 1'b0, 1'b1);
    check_pixels("point");

    // Full-screen diagonal, first without then with back-pressure.
    run_line(639, 479, 0, 0, 3'd7, 1'b0, 1'b0);
    ref_q = got;
    chk("diag_count", ref_q.size(), 640);
    if (ref_q.size() == 640) begin
      chk("diag_first", ref_q[0], {10'd639, 9'd479});
      chk("diag_last", ref_q[639], {10'd0, 9'd0});
      diffs = 0;
      for (int i = 1; i < 640; i++) begin
        if (ref_q[i-1][18:9] - ref_q[i][18:9] != 10'd1) diffs++;
        if (ref_q[i-1][8:0] - ref_q[i][8:0] > 9'd1) diffs++;
      end
      chk("diag_steps", diffs, 0);
    end
    run_line(639, 479, 0, 0, 3'd7, 1'b1, 1'b0);
    chk("diag_stall_count", got.size(), 640);
    diffs = 0;
    for (int i = 0; i < 640; i++)
      if (i < got.size() && i < ref_q.size() && got[i] !== ref_q[i]) diffs++;
    chk("diag_stall_seq", diffs, 0);

    // Abort on the third pixel.
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd10; y1 = 9'd0; color = 3'd2;
    line_valid = 1'b1; px_ready = 1'b1;
    step();
    line_valid = 1'b0;
    step();
    step();
    step();
    chk("abort_pix3", {px_valid, px_x, px_y}, {1'b1, 10'd2, 9'd0});
    abort = 1'b1;
    step();
    abort = 1'b0;
    px_ready = 1'b0;
    chk("abort_valid_low", px_valid, 0);
    chk("abort_ready_high", line_ready, 1);
    seen_done = int'(line_done);
    repeat (3) begin
      step();
      seen_done += int'(line_done);
    end
    chk("abort_no_done", seen_done, 0);
    exp_x = '{1, 2}; exp_y = '{1, 1};
    run_line(1, 1, 2, 1, 3'd4, 1'b0, 1'b0);
    check_pixels("after_abort");

    // Asynchronous reset in the middle of a line.
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd10; y1 = 9'd0; color = 3'd6;
    line_valid = 1'b1; px_ready = 1'b1;
    step();
    line_valid = 1'b0;
    step();
    step();
    chk("pre_rst_draw", {px_valid, px_x}, {1'b1, 10'd1});
    #2 rst = 1'b1;
    #1;
    chk("midrst_px_valid", px_valid, 0);
    chk("midrst_px_xy", {px_x, px_y}, 0);
    chk("midrst_px_color", px_color, 0);
    chk("midrst_line_ready", line_ready, 1);
    chk("midrst_line_done", line_done, 0);
    px_ready = 1'b0;
    rst = 1'b0;
    step();
    exp_x = '{3}; exp_y = '{4};
    run_line(3, 4, 3, 4, 3'd2, 1'b0, 1'b0);
    check_pixels("after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
